apb_clint: RTL and testbench

//   APB responder implementing the RISC-V core-local interruptor (CLINT) for a single hart.

---
 rtl/clint_pkg.sv | 20 ++
 rtl/clint_timer.sv | 35 +++
 rtl/apb_clint.sv | 66 ++++++
 tb/tb_apb_clint.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: CLINT register offsets, reset constants and byte-strobe merge helper
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// clint_timer: prescaler and 64-bit mtime counter with word-write load ports
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lo_we,
    input  logic        hi_we,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [63:0] mtime
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] pre;
    logic        wrap;

    assign wrap = pre == LAST;

    // prescaler free-runs 0..TICK_DIV-1, unaffected by mtime writes
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pre <= '0;
        else        pre <= wrap ? '0 : pre + 16'd1;

    // a word write wins over the tick and leaves the other word untouched
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)     mtime <= '0;
        else if (lo_we) mtime[31:0] <= apply_wstrb(mtime[31:0], wdata, wstrb);
        else if (hi_we) mtime[63:32] <= apply_wstrb(mtime[63:32], wdata, wstrb);
        else if (wrap)  mtime <= mtime + 64'd1;

endmodule

// File: rtl/apb_clint.sv
// apb_clint: APB CLINT responder with msip, mtimecmp, mtime and timer interrupt
module apb_clint
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    output logic        pready,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pwstrb,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        msip,
    output logic        mtip
);

    logic [15:0] off;
    logic        access, hit, we;
    logic [63:0] mtime, mtimecmp;
    logic        unused_hi;

    assign off       = paddr[15:0];
    assign unused_hi = ^paddr[31:16];
    assign access    = psel & penable;
    assign hit       = off inside {CLINT_MSIP, CLINT_MTIMECMP_LO, CLINT_MTIMECMP_HI, CLINT_MTIME_LO, CLINT_MTIME_HI};
    assign we        = access & pwrite & hit;
    assign pready    = access;
    assign pslverr   = access & ~hit;

    clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .lo_we (we && off == CLINT_MTIME_LO),
        .hi_we (we && off == CLINT_MTIME_HI),
        .wdata (pwdata),
        .wstrb (pwstrb),
        .mtime (mtime)
    );

    // read mux shows pre-edge register contents, zero outside a valid access
    always_comb
        prdata = !(access && hit)          ? 32'd0 :
                 off == CLINT_MSIP         ? {31'd0, msip} :
                 off == CLINT_MTIMECMP_LO  ? mtimecmp[31:0] :
                 off == CLINT_MTIMECMP_HI  ? mtimecmp[63:32] :
                 off == CLINT_MTIME_LO     ? mtime[31:0] : mtime[63:32];

    // msip, mtimecmp and the registered timer compare
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            msip     <= 1'b0;
            mtimecmp <= MTIMECMP_RST;
            mtip     <= 1'b0;
        end else begin
            mtip <= mtime >= mtimecmp;
            if (we && off == CLINT_MSIP && pwstrb[0]) msip <= pwdata[0];
            if (we && off == CLINT_MTIMECMP_LO) mtimecmp[31:0] <= apply_wstrb(mtimecmp[31:0], pwdata, pwstrb);
            if (we && off == CLINT_MTIMECMP_HI) mtimecmp[63:32] <= apply_wstrb(mtimecmp[63:32], pwdata, pwstrb);
        end

endmodule

// File: tb/tb_apb_clint.sv
// tb_apb_clint: scoreboard bench for two CLINT instances (TICK_DIV 1 and 4) against a reference model
module tb_apb_clint;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  psel;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pwstrb;
    logic [1:0]  pready, pslverr, msip, mtip;
    logic [31:0] prdata [2];

    always #5 clk = ~clk;

    apb_clint #(.TICK_DIV(1)) u0 (
        .clk(clk), .rst_n(rst_n), .psel(psel[0]), .penable(penable), .pready(pready[0]),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb), .prdata(prdata[0]),
        .pslverr(pslverr[0]), .msip(msip[0]), .mtip(mtip[0])
    );

    apb_clint #(.TICK_DIV(4)) u1 (
        .clk(clk), .rst_n(rst_n), .psel(psel[1]), .penable(penable), .pready(pready[1]),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb), .prdata(prdata[1]),
        .pslverr(pslverr[1]), .msip(msip[1]), .mtip(mtip[1])
    );

    typedef struct {
        bit          rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t q [2][$];
    int   ncmp = 0;
    int   nbad = 0;

    int unsigned     td [2] = '{1, 4};
    longint unsigned m_time [2];
    longint unsigned m_cmp [2];
    bit              m_msip [2];
    bit              m_mtip [2];
    int unsigned     m_cyc [2];

    function automatic bit mapped(input logic [31:0] a);
        return a[15:0] inside {16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input int i, input logic [31:0] a);
        case (a[15:0])
            16'h0000: return {31'd0, m_msip[i]};
            16'h4000: return m_cmp[i][31:0];
            16'h4004: return m_cmp[i][63:32];
            16'hBFF8: return m_time[i][31:0];
            16'hBFFC: return m_time[i][63:32];
            default:  return 32'd0;
        endcase
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // reference model: mtime advances on every td-th cycle since reset unless a word is written
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_time[i] <= 0;
                m_cmp[i]  <= 64'hFFFF_FFFF_FFFF_FFFF;
                m_msip[i] <= 0;
                m_mtip[i] <= 0;
                m_cyc[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                automatic bit wr = psel[i] && penable && pwrite && mapped(paddr);
                automatic bit tick = (m_cyc[i] % td[i]) == td[i] - 1;
                automatic logic [63:0] t = m_time[i];
                automatic logic [63:0] c = m_cmp[i];
                m_mtip[i] <= m_time[i] >= m_cmp[i];
                m_cyc[i]  <= m_cyc[i] + 1;
                if (wr && paddr[15:0] == 16'hBFF8)      m_time[i] <= {t[63:32], merge(t[31:0], pwdata, pwstrb)};
                else if (wr && paddr[15:0] == 16'hBFFC) m_time[i] <= {merge(t[63:32], pwdata, pwstrb), t[31:0]};
                else if (tick)                          m_time[i] <= t + 1;
                if (wr && paddr[15:0] == 16'h4000) m_cmp[i] <= {c[63:32], merge(c[31:0], pwdata, pwstrb)};
                if (wr && paddr[15:0] == 16'h4004) m_cmp[i] <= {merge(c[63:32], pwdata, pwstrb), c[31:0]};
                if (wr && paddr[15:0] == 16'h0000 && pwstrb[0]) m_msip[i] <= pwdata[0];
            end
        end

    // monitor: interrupt lines every cycle, bus responses whenever pready is up
    always @(negedge clk)
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mtip%0d", i), 64'(mtip[i]), 64'(m_mtip[i]));
            chk($sformatf("msip%0d", i), 64'(msip[i]), 64'(m_msip[i]));
            if (pready[i]) begin
                if (q[i].size() == 0) begin
                    chk($sformatf("unexpected_pready%0d", i), 64'(pready[i]), 64'd0);
                end else begin
                    automatic exp_t e = q[i].pop_front();
                    if (e.rd) chk($sformatf("prdata%0d@%h", i, paddr), 64'(prdata[i]), 64'(e.data));
                    chk($sformatf("pslverr%0d@%h", i, paddr), 64'(pslverr[i]), 64'(e.err));
                end
            end
        end

    task automatic idle(input int n);
        repeat (n) @(posedge clk) #1;
    endtask

    task automatic xfer(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        psel = '0;
        psel[i] = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = a;
        pwdata = d;
        pwstrb = s;
        @(posedge clk) #1;
        penable = 1'b1;
        q[i].push_back('{rd: !wr, data: wr ? 32'd0 : model_rd(i, a), err: !mapped(a)});
        @(posedge clk) #1;
        psel = '0;
        penable = 1'b0;
    endtask

    task automatic rd(input int i, input logic [31:0] a);
        xfer(i, 1'b0, a, $urandom, 4'hF);
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        xfer(i, 1'b1, a, d, s);
    endtask

    logic [15:0] offs [9] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC,
                              16'h0004, 16'h4001, 16'h8000, 16'hBFFA};

    initial begin
        psel = '0;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = '0;
        pwdata = '0;
        pwstrb = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 2; i++) begin
            rd(i, 32'h0000_BFF8);
            rd(i, 32'h0000_BFFC);
            rd(i, 32'h0000_4000);
            rd(i, 32'h0000_4004);
            rd(i, 32'h0000_0000);
        end
        idle(10);
        rd(0, 32'h0000_BFF8);

        wr(0, 32'h0000_BFF8, 32'h0, 4'hF);
        wr(0, 32'h0000_4004, 32'h0, 4'hF);
        wr(0, 32'h0000_4000, 32'h20, 4'hF);
        idle(40);
        rd(0, 32'h0000_BFF8);
        wr(0, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF);
        idle(3);

        wr(0, 32'h0000_BFFC, 32'h0, 4'hF);
        wr(0, 32'h0000_BFF8, 32'hFFFF_FFFE, 4'hF);
        rd(0, 32'h0000_BFFC);
        rd(0, 32'h0000_BFF8);
        idle(2);
        rd(0, 32'h0000_BFFC);
        rd(0, 32'h0000_BFF8);

        wr(0, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0001);
        rd(0, 32'h0000_0000);
        wr(0, 32'h0000_0000, 32'h0, 4'b0010);
        rd(0, 32'h0000_0000);

        rd(0, 32'h0000_0004);
        wr(0, 32'h0000_4001, 32'h1234_5678, 4'hF);
        rd(0, 32'h0000_4000);
        rd(0, 32'h0000_4004);

        while ((m_cyc[1] + 1) % 4 != 3) idle(1);
        wr(1, 32'h0000_BFF8, 32'h0000_0100, 4'hF);
        repeat (6) rd(1, 32'h0000_BFF8);

        repeat (300) begin
            automatic int i = $urandom_range(0, 1);
            automatic logic [15:0] o = offs[$urandom_range(0, 8)];
            automatic logic [31:0] d = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 200);
            xfer(i, 1'($urandom_range(0, 1)), {16'($urandom), o}, d, 4'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
        end

        psel = 2'b01;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h0000_4000;
        pwdata = 32'h0;
        pwstrb = 4'hF;
        @(posedge clk) #1;
        penable = 1'b1;
        q[0].push_back('{rd: 1'b0, data: 32'd0, err: 1'b0});
        rst_n = 1'b0;
        @(posedge clk) #1;
        psel = '0;
        penable = 1'b0;
        rst_n = 1'b1;
        rd(0, 32'h0000_4000);
        rd(0, 32'h0000_0000);
        rd(1, 32'h0000_BFF8);

        idle(2);
        chk("queue_empty", 64'(q[0].size() + q[1].size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
